// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the Sysbus arbiter: FSM states, requester
// indices and the fields of the bus request tag.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE  = 2'd0,
        BUS_ADDR  = 2'd1,
        BUS_WDATA = 2'd2,
        BUS_RDATA = 2'd3
    } bus_state_e;

    localparam int REQ_IFETCH = 0;
    localparam int REQ_DREAD  = 1;
    localparam int REQ_DWRITE = 2;

    // Tag layout: {~write, device, owner index}
    localparam int          TAG_RW_BIT     = 12;
    localparam int          TAG_OWNER_BITS = 8;
    localparam logic [3:0]  TAG_DEV_MEMORY = 4'b0001;

    // 8 beats of 8 bytes in the default configuration
    localparam int BLOCK_OFFSET_BITS = 6;

    function automatic int rr_slot(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the rr pointer,
// wrapping modulo NUM_REQ.
module rr_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [IDX_W-1:0] slot;

    // Walk from the farthest slot back to rr so the closest request wins last.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        slot    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            slot = IDX_W'(rr_slot(int'(rr_i), i, NUM_REQ));
            if (req_i[slot]) begin
                grant_o       = '0;
                grant_o[slot] = 1'b1;
                idx_o         = slot;
                valid_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Sysbus arbiter: serialises block fills/writebacks from the ifetch, data-read
// and data-write requesters, one outstanding transaction, round-robin order.
//
// state     | meaning
// IDLE      | no transaction; arbitrate among req_valid
// ADDR      | address beat on the bus, waiting for bus_reqack
// WDATA     | streaming BEATS write beats from wr_data
// RDATA     | collecting BEATS response beats tagged for the owner
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8,
    parameter int NUM_REQ        = 3
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_REQ-1:0]                      req_valid,
    input  logic [NUM_REQ-1:0][BUS_DATA_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]                      req_write,
    output logic [NUM_REQ-1:0]                      req_grant,
    output logic [NUM_REQ-1:0]                      busy,
    input  logic [BUS_DATA_WIDTH-1:0]               wr_data,
    output logic                                    wr_data_ready,
    output logic                                    wr_done,
    output logic [NUM_REQ-1:0]                      rd_valid,
    output logic [BUS_DATA_WIDTH-1:0]               rd_data,
    output logic [$clog2(BEATS)-1:0]                rd_beat,
    output logic                                    rd_last,
    output logic                                    bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]               bus_req,
    output logic [BUS_TAG_WIDTH-1:0]                bus_reqtag,
    input  logic                                    bus_reqack,
    input  logic                                    bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]               bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]                bus_resptag,
    output logic                                    bus_respack
);

    localparam int IDX_W    = $clog2(NUM_REQ);
    localparam int BEAT_W   = $clog2(BEATS);
    localparam int OFF_BITS = $clog2(BEATS * 8);
    localparam logic [BUS_DATA_WIDTH-1:0] BASE_MASK = {BUS_DATA_WIDTH{1'b1}} << OFF_BITS;

    bus_state_e                state_q, state_d;
    logic [IDX_W-1:0]          rr_q, rr_d;
    logic [IDX_W-1:0]          owner_q, owner_d;
    logic [BUS_DATA_WIDTH-1:0] addr_q, addr_d;
    logic                      write_q, write_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [NUM_REQ-1:0]        busy_q, busy_d;

    logic [NUM_REQ-1:0]        pick_onehot;
    logic [IDX_W-1:0]          pick_idx;
    logic                      pick_valid;

    logic [NUM_REQ-1:0]        owner_onehot;
    logic [TAG_OWNER_BITS-1:0] owner_ext;
    logic [IDX_W-1:0]          owner_next;
    logic [BUS_TAG_WIDTH-1:0]  tag;
    logic                      last_beat;
    logic                      rd_hit;
    logic                      unused_tag_bits;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i   (req_valid),
        .rr_i    (rr_q),
        .grant_o (pick_onehot),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign owner_onehot = NUM_REQ'(1) << owner_q;
    assign owner_ext    = {{(TAG_OWNER_BITS - IDX_W){1'b0}}, owner_q};
    assign owner_next   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
    assign last_beat    = (beat_q == BEAT_W'(BEATS - 1));
    assign rd_hit       = (state_q == BUS_RDATA) && bus_respcyc
                          && (bus_resptag[TAG_OWNER_BITS-1:0] == owner_ext);
    assign unused_tag_bits = ^bus_resptag[BUS_TAG_WIDTH-1:TAG_OWNER_BITS];

    always_comb begin
        tag                              = '0;
        tag[TAG_OWNER_BITS-1:0]          = owner_ext;
        tag[TAG_RW_BIT-1 -: 4]           = TAG_DEV_MEMORY;
        tag[TAG_RW_BIT]                  = ~write_q;
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        write_d = write_q;
        beat_d  = beat_q;
        busy_d  = busy_q;
        case (state_q)
            BUS_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    addr_d  = req_addr[pick_idx];
                    write_d = req_write[pick_idx];
                    busy_d  = busy_q | pick_onehot;
                    beat_d  = '0;
                    state_d = BUS_ADDR;
                end
            end
            BUS_ADDR: begin
                if (bus_reqack) begin
                    state_d = write_q ? BUS_WDATA : BUS_RDATA;
                end
            end
            BUS_WDATA: begin
                beat_d = beat_q + BEAT_W'(1);
                if (last_beat) begin
                    state_d = BUS_IDLE;
                    busy_d  = busy_q & ~owner_onehot;
                    rr_d    = owner_next;
                end
            end
            BUS_RDATA: begin
                // Beats for other tags are acked but neither counted nor forwarded.
                if (rd_hit) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (last_beat) begin
                        state_d = BUS_IDLE;
                        busy_d  = busy_q & ~owner_onehot;
                        rr_d    = owner_next;
                    end
                end
            end
            default: state_d = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BUS_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            beat_q  <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            beat_q  <= beat_d;
            busy_q  <= busy_d;
        end
    end

    assign busy          = busy_q;
    assign req_grant     = (state_q == BUS_ADDR && bus_reqack) ? owner_onehot : '0;
    assign bus_reqcyc    = (state_q == BUS_ADDR) || (state_q == BUS_WDATA);
    assign bus_req       = (state_q == BUS_ADDR)  ? (addr_q & BASE_MASK) :
                           (state_q == BUS_WDATA) ? wr_data : '0;
    assign bus_reqtag    = bus_reqcyc ? tag : '0;
    assign wr_data_ready = (state_q == BUS_WDATA);
    assign wr_done       = (state_q == BUS_WDATA) && last_beat;
    // Every response beat is acked in any state, but never while reset is held.
    assign bus_respack   = reset && bus_respcyc;
    assign rd_valid      = rd_hit ? owner_onehot : '0;
    assign rd_data       = rd_hit ? bus_resp : '0;
    assign rd_beat       = rd_hit ? beat_q : '0;
    assign rd_last       = rd_hit && last_beat;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a table of response beats for one read fill,
// plus hand-written sequences for arbitration order, writes, stalls and reset.
module tb_bus_arbiter;

    logic              clk;
    logic              reset;
    logic [2:0]        req_valid;
    logic [2:0][63:0]  req_addr;
    logic [2:0]        req_write;
    logic [2:0]        req_grant;
    logic [2:0]        busy;
    logic [63:0]       wr_data;
    logic              wr_data_ready;
    logic              wr_done;
    logic [2:0]        rd_valid;
    logic [63:0]       rd_data;
    logic [2:0]        rd_beat;
    logic              rd_last;
    logic              bus_reqcyc;
    logic [63:0]       bus_req;
    logic [12:0]       bus_reqtag;
    logic              bus_reqack;
    logic              bus_respcyc;
    logic [63:0]       bus_resp;
    logic [12:0]       bus_resptag;
    logic              bus_respack;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        respcyc;
        logic [12:0] tag;
        logic [63:0] data;
        logic        exp_ack;
        logic [2:0]  exp_valid;
        logic [2:0]  exp_beat;
        logic        exp_last;
    } beat_vec_t;

    beat_vec_t vecs [11];

    bus_arbiter #(
        .BUS_DATA_WIDTH (64),
        .BUS_TAG_WIDTH  (13),
        .BEATS          (8),
        .NUM_REQ        (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_write     (req_write),
        .req_grant     (req_grant),
        .busy          (busy),
        .wr_data       (wr_data),
        .wr_data_ready (wr_data_ready),
        .wr_done       (wr_done),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_beat       (rd_beat),
        .rd_last       (rd_last),
        .bus_reqcyc    (bus_reqcyc),
        .bus_req       (bus_req),
        .bus_reqtag    (bus_reqtag),
        .bus_reqack    (bus_reqack),
        .bus_respcyc   (bus_respcyc),
        .bus_resp      (bus_resp),
        .bus_resptag   (bus_resptag),
        .bus_respack   (bus_respack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " reqcyc"},  64'(bus_reqcyc), 64'd0);
        chk({name, " respack"}, 64'(bus_respack), 64'd0);
        chk({name, " grant"},   64'(req_grant), 64'd0);
        chk({name, " busy"},    64'(busy), 64'd0);
        chk({name, " rdvalid"}, 64'(rd_valid), 64'd0);
        chk({name, " wrready"}, 64'(wr_data_ready), 64'd0);
        chk({name, " bus_req"}, bus_req, 64'd0);
        chk({name, " rd_last"}, 64'(rd_last), 64'd0);
    endtask

    // One full transaction for the given owner, starting from the cycle in
    // which its request is visible to the arbiter.
    task automatic do_txn(input int owner, input logic wr, input logic [63:0] exp_addr,
                          input int ack_delay, input logic [2:0] reassert);
        logic [12:0] etag;
        logic [2:0]  eoh;
        int          n;
        etag = {~wr, 4'b0001, 8'(owner)};
        eoh  = 3'(1 << owner);
        n    = 0;
        tick();
        while (!bus_reqcyc && n < 10) begin
            tick();
            n++;
        end
        if (!bus_reqcyc) begin
            chk("addr phase timeout", 64'(bus_reqcyc), 64'd1);
            return;
        end
        chk("txn tag", 64'(bus_reqtag), 64'(etag));
        chk("txn addr", bus_req, exp_addr);
        chk("txn busy", 64'(busy), 64'(eoh));
        for (int d = 0; d < ack_delay; d++) begin
            chk("stall grant", 64'(req_grant), 64'd0);
            chk("stall addr", bus_req, exp_addr);
            chk("stall tag", 64'(bus_reqtag), 64'(etag));
            chk("stall reqcyc", 64'(bus_reqcyc), 64'd1);
            tick();
        end
        bus_reqack = 1'b1;
        #1;
        chk("txn grant", 64'(req_grant), 64'(eoh));
        tick();
        bus_reqack       = 1'b0;
        req_valid[owner] = 1'b0;
        req_valid        = req_valid | reassert;
        if (wr) begin
            for (int k = 0; k < 8; k++) begin
                wr_data = 64'hA0 + 64'(k);
                #1;
                chk("wr ready", 64'(wr_data_ready), 64'd1);
                chk("wr bus_req", bus_req, 64'hA0 + 64'(k));
                chk("wr reqcyc", 64'(bus_reqcyc), 64'd1);
                chk("wr done", 64'(wr_done), (k == 7) ? 64'd1 : 64'd0);
                tick();
            end
            chk("wr ready after", 64'(wr_data_ready), 64'd0);
        end else begin
            for (int k = 0; k < 8; k++) begin
                bus_respcyc = 1'b1;
                bus_resptag = {1'b1, 4'b0001, 8'(owner)};
                bus_resp    = 64'hB000_0000_0000_0000 + 64'(owner * 256 + k);
                #1;
                chk("rd valid", 64'(rd_valid), 64'(eoh));
                chk("rd beat", 64'(rd_beat), 64'(k));
                chk("rd last", 64'(rd_last), (k == 7) ? 64'd1 : 64'd0);
                chk("rd data", rd_data, 64'hB000_0000_0000_0000 + 64'(owner * 256 + k));
                tick();
            end
            bus_respcyc = 1'b0;
        end
        #1;
        chk("txn busy cleared", 64'(busy[owner]), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 13'h1100, 64'hC0DE_0000_0000_0000, 1'b1, 3'b001, 3'd0, 1'b0};
        vecs[1]  = '{1'b1, 13'h1100, 64'hC0DE_0000_0000_0001, 1'b1, 3'b001, 3'd1, 1'b0};
        vecs[2]  = '{1'b0, 13'h1100, 64'h0,                   1'b0, 3'b000, 3'd0, 1'b0};
        vecs[3]  = '{1'b1, 13'h1101, 64'hDEAD_DEAD_DEAD_DEAD, 1'b1, 3'b000, 3'd0, 1'b0};
        vecs[4]  = '{1'b1, 13'h1100, 64'hC0DE_0000_0000_0002, 1'b1, 3'b001, 3'd2, 1'b0};
        vecs[5]  = '{1'b1, 13'h0102, 64'hDEAD_BEEF_0000_0000, 1'b1, 3'b000, 3'd0, 1'b0};
        vecs[6]  = '{1'b1, 13'h1100, 64'hC0DE_0000_0000_0003, 1'b1, 3'b001, 3'd3, 1'b0};
        vecs[7]  = '{1'b1, 13'h1100, 64'hC0DE_0000_0000_0004, 1'b1, 3'b001, 3'd4, 1'b0};
        vecs[8]  = '{1'b1, 13'h1100, 64'hC0DE_0000_0000_0005, 1'b1, 3'b001, 3'd5, 1'b0};
        vecs[9]  = '{1'b1, 13'h1100, 64'hC0DE_0000_0000_0006, 1'b1, 3'b001, 3'd6, 1'b0};
        vecs[10] = '{1'b1, 13'h1100, 64'hC0DE_0000_0000_0007, 1'b1, 3'b001, 3'd7, 1'b1};

        reset       = 1'b0;
        req_valid   = 3'b000;
        req_addr    = '0;
        req_write   = 3'b000;
        wr_data     = 64'd0;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b1;
        bus_resp    = 64'h1234;
        bus_resptag = 13'h1100;
        #3;
        chk_all_zero("reset");
        bus_respcyc = 1'b0;
        tick();
        reset = 1'b1;

        // Single ifetch read at 0x1044, ack in cycle 3.
        req_valid   = 3'b001;
        req_addr[0] = 64'h1044;
        tick();
        chk("t1 reqcyc c1", 64'(bus_reqcyc), 64'd1);
        chk("t1 addr c1", bus_req, 64'h1040);
        chk("t1 tag c1", 64'(bus_reqtag), 64'h1100);
        chk("t1 busy c1", 64'(busy), 64'b001);
        chk("t1 grant c1", 64'(req_grant), 64'd0);
        tick();
        chk("t1 addr c2", bus_req, 64'h1040);
        chk("t1 grant c2", 64'(req_grant), 64'd0);
        tick();
        bus_reqack = 1'b1;
        #1;
        chk("t1 grant c3", 64'(req_grant), 64'b001);
        tick();
        bus_reqack = 1'b0;
        req_valid  = 3'b000;

        for (int i = 0; i < 11; i++) begin
            bus_respcyc = vecs[i].respcyc;
            bus_resptag = vecs[i].tag;
            bus_resp    = vecs[i].data;
            #1;
            chk($sformatf("vec%0d respack", i), 64'(bus_respack), 64'(vecs[i].exp_ack));
            chk($sformatf("vec%0d rd_valid", i), 64'(rd_valid), 64'(vecs[i].exp_valid));
            chk($sformatf("vec%0d rd_last", i), 64'(rd_last), 64'(vecs[i].exp_last));
            if (vecs[i].exp_valid != 3'b000) begin
                chk($sformatf("vec%0d rd_beat", i), 64'(rd_beat), 64'(vecs[i].exp_beat));
                chk($sformatf("vec%0d rd_data", i), rd_data, vecs[i].data);
            end
            tick();
        end
        bus_respcyc = 1'b0;
        #1;
        chk("t1 busy end", 64'(busy), 64'd0);
        chk("t1 reqcyc end", 64'(bus_reqcyc), 64'd0);

        // Reset pulse so rr starts at 0, then all three request together.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        req_addr[0] = 64'h1044;
        req_addr[1] = 64'h8008;
        req_addr[2] = 64'h2000;
        req_write   = 3'b100;
        req_valid   = 3'b111;
        do_txn(0, 1'b0, 64'h1040, 0, 3'b000);
        do_txn(1, 1'b0, 64'h8000, 0, 3'b001);
        do_txn(2, 1'b1, 64'h2000, 0, 3'b000);
        do_txn(0, 1'b0, 64'h1040, 0, 3'b000);

        // Address beat held for 5 cycles without ack.
        req_addr[1] = 64'h3FFF;
        req_valid   = 3'b010;
        do_txn(1, 1'b0, 64'h3FC0, 5, 3'b000);

        // Stray response while idle.
        bus_respcyc = 1'b1;
        bus_resptag = 13'h1105;
        bus_resp    = 64'h5555;
        #1;
        chk("stray respack", 64'(bus_respack), 64'd1);
        chk("stray rd_valid", 64'(rd_valid), 64'd0);
        tick();
        bus_respcyc = 1'b0;

        // Reset in the middle of a read fill.
        req_addr[0] = 64'h1044;
        req_valid   = 3'b001;
        tick();
        chk("rst txn reqcyc", 64'(bus_reqcyc), 64'd1);
        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0;
        req_valid  = 3'b000;
        for (int k = 0; k < 4; k++) begin
            bus_respcyc = 1'b1;
            bus_resptag = 13'h1100;
            bus_resp    = 64'(k);
            #1;
            chk("rst pre beat", 64'(rd_beat), 64'(k));
            tick();
        end
        bus_resp = 64'd4;
        reset    = 1'b0;
        #1;
        chk_all_zero("midreset");
        tick();
        reset = 1'b1;
        for (int k = 4; k < 8; k++) begin
            bus_resp = 64'(k);
            #1;
            chk("late respack", 64'(bus_respack), 64'd1);
            chk("late rd_valid", 64'(rd_valid), 64'd0);
            tick();
        end
        bus_respcyc = 1'b0;
        req_addr[1] = 64'h5010;
        req_valid   = 3'b010;
        do_txn(1, 1'b0, 64'h5000, 0, 3'b000);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single Sysbus port between three block-fill requesters: instruction read, data read and data write (dirty-line writeback).
- Sits between the cache and the top-level bus pins and owns bus_reqcyc, bus_req, bus_reqtag and bus_respack.
- One transaction is outstanding at a time, and requesters are chosen round-robin.
- Read beats are routed back to the owning requester by tag.

Parameters:
BUS_DATA_WIDTH, 64, bus data/address width
BUS_TAG_WIDTH, 13, bus tag width
BEATS, 8, 64-bit beats per cache block (a power of 2)
NUM_REQ, 3, requesters (0=ifetch read, 1=data read, 2=data write)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
req_valid  in  NUM_REQ  request pending, one bit per requester
req_addr  in  NUM_REQ x 64  request byte address, one per requester
req_write  in  NUM_REQ  1 = write transaction
req_grant  out  NUM_REQ  one-cycle pulse when the address beat is acknowledged
busy  out  NUM_REQ  requester currently in service
wr_data  in  BUS_DATA_WIDTH  write beat from the granted writer
wr_data_ready  out  1  wr_data is consumed this cycle
wr_done  out  1  pulse on the last write beat
rd_valid  out  NUM_REQ  one-hot read beat valid
rd_data  out  BUS_DATA_WIDTH  read beat
rd_beat  out  log2(BEATS)  index of the read beat
rd_last  out  1  final read beat
bus_reqcyc  out  1  Sysbus request cycle
bus_req  out  BUS_DATA_WIDTH  address or write data
bus_reqtag  out  BUS_TAG_WIDTH  request tag
bus_reqack  in  1  bus accepts the address beat
bus_respcyc  in  1  response beat valid
bus_resp  in  BUS_DATA_WIDTH  response data
bus_resptag  in  BUS_TAG_WIDTH  response tag
bus_respack  out  1  response beat acknowledged

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr pointer=0, beat counter=0.
  - All outputs are 0, including bus_reqcyc, bus_respack, req_grant, busy, rd_valid and wr_data_ready.
- FSM states: IDLE, ADDR, WDATA, RDATA.
- IDLE:
  - If any req_valid is set, pick the first set bit at or after rr (wrapping modulo NUM_REQ).
  - Register the owner, the address and the write flag, set busy[owner], and go to ADDR.
  - Latency from req_valid to bus_reqcyc is 1 cycle.
- ADDR:
  - bus_reqcyc=1.
  - bus_req = addr with its low log2(BEATS*8) bits cleared.
  - bus_reqtag = {~write, 4'b0001, 8-bit owner index}.
  - Hold all three until bus_reqack.
  - On bus_reqack: pulse req_grant[owner] and go to WDATA if write, else RDATA.
- WDATA:
  - bus_reqcyc=1, bus_req=wr_data, wr_data_ready=1 every cycle; no per-beat ack is required.
  - After BEATS beats: pulse wr_done, then go to IDLE.
- RDATA:
  - bus_respack = bus_respcyc, combinational.
  - A beat with resptag[7:0]==owner drives rd_valid[owner], rd_data=bus_resp and rd_beat=counter, then increments the counter.
  - A beat with a mismatched tag is acked and dropped.
  - The beat with counter==BEATS-1 asserts rd_last, then the FSM goes to IDLE.
- Completion (any state returning to IDLE):
  - Clear busy[owner].
  - Set rr = owner+1 modulo NUM_REQ, so the served requester gets lowest priority.
- Requester rules:
  - req_valid and req_addr must stay stable until req_grant.
  - Dropping req_valid before the grant is illegal.
  - A requester may re-request in the cycle after its own completion.
- Stray responses: bus_respcyc seen in IDLE, ADDR or WDATA is acked (bus_respack=1) and discarded.
- Reset mid-operation:
  - The FSM aborts immediately to IDLE and the in-flight transaction is abandoned.
  - Late response beats from it are acked and dropped.
- Simultaneous completion and new req_valid: the rr pointer already reflects the completion; arbitration happens in the next IDLE cycle.
- The beat counter is log2(BEATS) bits and wraps to 0 on the last beat.

Decomposition:
- Shared package: the bus_state enum, requester index constants (REQ_IFETCH, REQ_DREAD, REQ_DWRITE), the tag field constants (TAG_RW_BIT=12, TAG_DEV_MEMORY=4'b0001) and a BLOCK_OFFSET_BITS constant.
- Sub-module rr_arbiter: combinational NUM_REQ-way round-robin pick, taking the request vector and rr pointer and returning a one-hot grant and the winner index.

Test Plan:
- Single ifetch read, addr 0x1044:
  - bus_req=0x1040 and tag=0x1100 from cycle 1; reqack in cycle 3 -> req_grant[0] pulse.
  - 8 resp beats 0..7 -> rd_valid[0] with rd_beat 0..7, rd_last on beat 7; busy[0] clears.
- All three requests valid at once, rr=0:
  - Served order is 0,1,2.
  - Re-asserting req 0 during service of 1 -> order becomes 2 then 0.
- Write request 2, addr 0x2000:
  - tag=0x0102 (write); after reqack, 8 consecutive cycles of wr_data_ready.
  - bus_req mirrors wr_data 0xA0..0xA7; wr_done on the 8th beat.
- bus_reqack delayed 5 cycles -> address and tag held stable and no grant until the ack.
- Stray respcyc in IDLE with tag 0x1105 -> respack=1, no rd_valid.
- Mismatched-tag beat during RDATA -> acked and dropped, beat counter unchanged.
- reset driven low after read beat 3 -> all outputs 0 asynchronously.
  - After release, remaining beats are acked and dropped; a new request proceeds normally.
